// File: rtl/rr_mux4_arbiter_pkg.sv
// rtl/rr_mux4_arbiter_pkg.sv - shared types, sizes and pick function for the round-robin mux4 arbiter
//
// Package rr_arb_pkg
//   NREQ        number of requesters
//   SEL_W       width of a requester index / mux select
//   arb_state_t output register state (IDLE: empty, FULL: holds an unaccepted word)
//   rr_pick()   round-robin pick starting one past the last granted source
package rr_arb_pkg;

   localparam int NREQ  = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } arb_state_t;

   // Scans (last+1), (last+2), ... wrapping, so the last winner is looked at
   // only after every other source. With no request the result is don't-care;
   // callers qualify it with |req.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                                input logic [SEL_W-1:0] last);
      logic [SEL_W-1:0] idx;
      logic             found;
      rr_pick = last + SEL_W'(1);
      found   = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = last + SEL_W'(i);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// rtl/rr_mux4_arbiter_if.sv - requester/consumer bundle of the round-robin mux4 arbiter
//
// Signals
//   req[3:0]        request per source, held with stable data until its gnt bit
//   d0..d3[N-1:0]   source data words
//   gnt[3:0]        one-hot combinational grant
//   s[1:0]          registered select of the captured source
//   y[N-1:0]        registered captured data
//   out_valid       y/s hold a transfer not yet accepted
//   out_ready       downstream accepts y at posedge when out_valid & out_ready
// Modports
//   master  requesters and downstream consumer (drive req/data/out_ready)
//   slave   the arbiter
interface rr_mux4_arbiter_if
   import rr_arb_pkg::*;
#(
   parameter int N = 64
);

   logic [NREQ-1:0]  req;
   logic [N-1:0]     d0;
   logic [N-1:0]     d1;
   logic [N-1:0]     d2;
   logic [N-1:0]     d3;
   logic [NREQ-1:0]  gnt;
   logic [SEL_W-1:0] s;
   logic [N-1:0]     y;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output req, d0, d1, d2, d3, out_ready,
      input  gnt, s, y, out_valid
   );

   modport slave (
      input  req, d0, d1, d2, d3, out_ready,
      output gnt, s, y, out_valid
   );

endinterface

// File: rtl/rr_mux4_arbiter_mux4.sv
// rtl/rr_mux4_arbiter_mux4.sv - combinational 4:1 multiplexer used as the arbiter data path
//
// Ports
//   d0..d3 [N-1:0]  data inputs
//   s      [1:0]    select
//   y      [N-1:0]  selected data
module mux4 #(
   parameter int N = 64
) (
   input  logic [N-1:0] d0,
   input  logic [N-1:0] d1,
   input  logic [N-1:0] d2,
   input  logic [N-1:0] d3,
   input  logic [1:0]   s,
   output logic [N-1:0] y
);

   always_comb begin
      y = d0;
      case (s)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// rtl/rr_mux4_arbiter.sv - round-robin arbiter sharing one registered 4:1 data path between four requesters
//
// Ports
//   clk     system clock, posedge
//   reset   asynchronous active-low reset
//   bus     rr_mux4_arbiter_if.slave: req, d0..d3, gnt, s, y, out_valid, out_ready
//   cnt     [63:0] packed 16-bit saturating grant counters, cnt[16*i+:16] for source i
//           (present only when RR_MUX4_STATS_EN is defined)
// Build option
//   RR_MUX4_STATS_EN  adds the cnt port and its counters
module rr_mux4_arbiter
   import rr_arb_pkg::*;
#(
   parameter int N = 64
) (
   input  logic               clk,
   input  logic               reset,
   rr_mux4_arbiter_if.slave   bus
`ifdef RR_MUX4_STATS_EN
   ,
   output logic [63:0]        cnt
`endif
);

   arb_state_t       state_q;
   arb_state_t       state_d;
   logic [SEL_W-1:0] last_q;
   logic [SEL_W-1:0] s_q;
   logic [N-1:0]     y_q;
   logic [N-1:0]     mux_y;
   logic [SEL_W-1:0] pick;
   logic             cap;
   logic             any_req;
   logic [NREQ-1:0]  gnt_c;

   assign any_req = |bus.req;
   assign pick    = rr_pick(bus.req, last_q);

   // The output register may load when empty, or when its current word is
   // being accepted in this same cycle, which allows one transfer per cycle.
   assign cap = (state_q == IDLE) || bus.out_ready;

   mux4 #(.N(N)) u_mux4 (
      .d0 (bus.d0),
      .d1 (bus.d1),
      .d2 (bus.d2),
      .d3 (bus.d3),
      .s  (pick),
      .y  (mux_y)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // gnt is gated by reset so no requester sees a grant that will be lost.
   always_comb begin
      state_d = state_q;
      gnt_c   = '0;
      if (cap) begin
         state_d = any_req ? FULL : IDLE;
      end
      if (reset && cap && any_req) begin
         gnt_c[pick] = 1'b1;
      end
   end

   // Pointer starts at 3 so source 0 is first after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= SEL_W'(NREQ - 1);
         s_q    <= '0;
         y_q    <= '0;
      end else if (cap && any_req) begin
         last_q <= pick;
         s_q    <= pick;
         y_q    <= mux_y;
      end
   end

   assign bus.gnt       = gnt_c;
   assign bus.s         = s_q;
   assign bus.y         = y_q;
   assign bus.out_valid = (state_q == FULL);

`ifdef RR_MUX4_STATS_EN
   logic [15:0] cnt_q [NREQ];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (gnt_c[i] && (cnt_q[i] != 16'hFFFF)) begin
               cnt_q[i] <= cnt_q[i] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         cnt[16*i +: 16] = cnt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// tb/tb_rr_mux4_arbiter.sv - directed self-checking bench for rr_mux4_arbiter
module tb_rr_mux4_arbiter;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   localparam logic [63:0] D0 = 64'hfafafa;
   localparam logic [63:0] D1 = 64'hc0cac01a;
   localparam logic [63:0] D2 = 64'h939ca;
   localparam logic [63:0] D3 = 64'h71aca;

   rr_mux4_arbiter_if #(.N(64)) bus ();

`ifdef RR_MUX4_STATS_EN
   logic [63:0] cnt;
   rr_mux4_arbiter #(.N(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .cnt   (cnt)
   );
`else
   rr_mux4_arbiter #(.N(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [63:0] dtab [4];
   int          order [5];

   initial begin
      errors = 0;
      checks = 0;
      dtab[0] = D0; dtab[1] = D1; dtab[2] = D2; dtab[3] = D3;
      order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

      reset         = 1'b0;
      bus.req       = 4'b0000;
      bus.d0        = D0;
      bus.d1        = D1;
      bus.d2        = D2;
      bus.d3        = D3;
      bus.out_ready = 1'b0;
      step();
      step();
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_y", bus.y, 64'd0);
      check("rst_s", 64'(bus.s), 64'd0);
      bus.req = 4'b0001;
      #1;
      check("rst_gnt_forced", 64'(bus.gnt), 64'd0);

      // first transfer: gnt same cycle, data next cycle
      reset         = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      check("first_gnt", 64'(bus.gnt), 64'h1);
      step();
      check("first_valid", 64'(bus.out_valid), 64'd1);
      check("first_y", bus.y, D0);
      check("first_s", 64'(bus.s), 64'd0);

      // stall with a word in flight, then async reset discards it
      bus.req       = 4'b0000;
      bus.out_ready = 1'b0;
      step();
      check("hold_y", bus.y, D0);
      reset = 1'b0;
      #1;
      check("async_valid", 64'(bus.out_valid), 64'd0);
      check("async_y", bus.y, 64'd0);
      check("async_s", 64'(bus.s), 64'd0);
      step();
      reset = 1'b1;

      // fairness with all requests held
      bus.req       = 4'b1111;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("rr_gnt%0d", k), 64'(bus.gnt), 64'(4'b0001 << order[k]));
         step();
         check($sformatf("rr_s%0d", k), 64'(bus.s), 64'(order[k]));
         check($sformatf("rr_y%0d", k), bus.y, dtab[order[k]]);
         check($sformatf("rr_v%0d", k), 64'(bus.out_valid), 64'd1);
      end

      // back-pressure: load source 1, then stall with source 2 waiting
      bus.req = 4'b0010;
      #1;
      check("bp_load_gnt", 64'(bus.gnt), 64'h2);
      step();
      check("bp_load_y", bus.y, D1);
      bus.req       = 4'b0100;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp_gnt%0d", k), 64'(bus.gnt), 64'd0);
         step();
         check($sformatf("bp_y%0d", k), bus.y, D1);
         check($sformatf("bp_s%0d", k), 64'(bus.s), 64'd1);
         check($sformatf("bp_v%0d", k), 64'(bus.out_valid), 64'd1);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_gnt", 64'(bus.gnt), 64'h4);
      step();
      check("bp_release_y", bus.y, D2);
      check("bp_release_s", 64'(bus.s), 64'd2);

      // wrap priority
      bus.req = 4'b1000;
      #1;
      check("wrap_pre_gnt", 64'(bus.gnt), 64'h8);
      step();
      bus.req = 4'b1001;
      #1;
      check("wrap_last3_gnt", 64'(bus.gnt), 64'h1);
      step();
      check("wrap_last3_s", 64'(bus.s), 64'd0);
      #1;
      check("wrap_last0_gnt", 64'(bus.gnt), 64'h8);
      step();
      check("wrap_last0_s", 64'(bus.s), 64'd3);
      check("wrap_last0_y", bus.y, D3);

      // drain to idle: y/s retained
      bus.req = 4'b0000;
      step();
      check("idle_valid", 64'(bus.out_valid), 64'd0);
      check("idle_y", bus.y, D3);
      check("idle_s", 64'(bus.s), 64'd3);
      check("idle_gnt", 64'(bus.gnt), 64'd0);

`ifdef RR_MUX4_STATS_EN
      reset = 1'b0;
      #1;
      check("cnt_rst", cnt, 64'd0);
      reset   = 1'b1;
      bus.req = 4'b0100;
      repeat (5) step();
      bus.req = 4'b0000;
      #1;
      check("cnt_five", cnt, {16'h0, 16'd5, 16'h0, 16'h0});
      bus.req = 4'b0100;
      repeat (65530) step();
      bus.req = 4'b0000;
      #1;
      check("cnt_max", cnt, {16'h0, 16'hFFFF, 16'h0, 16'h0});
      bus.req = 4'b0100;
      step();
      bus.req = 4'b0000;
      #1;
      check("cnt_sat", cnt, {16'h0, 16'hFFFF, 16'h0, 16'h0});
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter that shares one registered 4:1 data path between four requesters.
- Picks one pending requester per accepted transfer and drives the mux4 select from the grant.
- Captures the selected word into an output register and presents it downstream over a valid/ready handshake.
- Sits in front of any shared 64-bit consumer, such as a write-back or memory port, that multiple datapath sources contend for.

Parameters:
N, 64, data width of each requester word and of y

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-low reset
req  input  4  request per source; held high with stable data until its gnt bit is seen
d0  input  N  source 0 data
d1  input  N  source 1 data
d2  input  N  source 2 data
d3  input  N  source 3 data
gnt  output  4  one-hot combinational grant; high in the cycle the source's data is captured
s  output  2  select of the captured source, registered
y  output  N  captured data, registered
out_valid  output  1  y/s hold a transfer not yet accepted
out_ready  input  1  downstream accepts y when out_valid & out_ready at posedge

Behaviour:
- Reset (reset low, async): out_valid=0, y=0, s=2'b00, last-grant pointer=3 so source 0 has first priority, state=IDLE. gnt is forced to 0 while reset is low.
- States:
  - IDLE: out_valid=0.
  - FULL: out_valid=1.
- cap (capture enable) = (state==IDLE) | (state==FULL & out_ready).
- pick: first asserted req scanning from (last+1) mod 4 upward, wrapping. Computed combinationally.
- gnt = cap & |req ? onehot(pick) : 4'b0. Exactly one bit at most.
- On posedge with cap & |req:
  - y <= mux4(d0..d3, pick), s <= pick, last <= pick.
  - State goes to or stays in FULL.
  - A full-throughput transfer every cycle is allowed.
- On posedge with cap & ~|req: state <= IDLE. y and s retain their old values.
- FULL & ~out_ready: hold y, s, out_valid. gnt=0 and last is unchanged, so a stalled consumer never loses data.
- Latency: req at cycle k with out_valid=0 gives gnt in cycle k and out_valid/y at k+1.
- Fairness: with all four req held high, grant order is 0,1,2,3,0,...; no source waits more than 3 transfers.
- Requesters must drop or change req/data only after seeing gnt. A req deasserted before gnt is simply not served; no error is raised.
- Mid-operation reset: an in-flight word is discarded, out_valid drops immediately (async), and priority returns to source 0.

Optional Feature:
RR_MUX4_STATS_EN
- Defined:
  - Adds output cnt [63:0], four packed 16-bit grant counters: cnt[16*i+:16] for source i.
  - Each counter increments on posedge when gnt[i]=1, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package rr_arb_pkg:
  - NREQ=4, SEL_W=2.
  - typedef enum logic {IDLE, FULL} arb_state_t.
  - function rr_pick(req, last), returning the 2-bit pick.
- Sub-module: instantiate existing mux4 #(N) for data selection with s=pick.
- The arbiter holds only pointer, FSM and output register.

Test Plan:
- Reset low mid-transfer (out_valid=1, y=64'hfafafa) -> out_valid=0, y=0, s=0 immediately, without waiting for a clock edge.
- After reset, req=4'b0001, d0=64'hfafafa, out_ready=1 -> gnt=4'b0001 in the same cycle; next cycle out_valid=1, y=64'hfafafa, s=0.
- req=4'b1111 held, out_ready=1, d0..d3=64'hfafafa, 64'hc0cac01a, 64'h939ca, 64'h71aca -> s sequence 0,1,2,3,0 and y matches on consecutive cycles, one gnt bit per cycle.
- Back-pressure: out_valid=1, y=64'hc0cac01a, out_ready=0 for 3 cycles with req=4'b0100 -> y and s stable, gnt=0. When out_ready=1: gnt=4'b0100 and next y=64'h939ca.
- Wrap priority: last=3, req=4'b1001 -> pick 0; then last=0, req=4'b1001 -> pick 3.
- With RR_MUX4_STATS_EN: 5 grants to source 2 -> cnt[47:32]=5, other counters 0. With the counter preloaded to 16'hFFFF, a further grant keeps it at 16'hFFFF.
